matmul_tile_ctrl: RTL and testbench

// APB-programmable control/sequencer for the fp8 matrix_multiplication core. Holds base

---
 rtl/matmul_tile_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_matmul_tile_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_ctrl.sv
// APB sequencer for the fp8 matmul core: issues one core_start per tile, steps A/B/C bases, gathers flags.
// Optional interrupt logic is compiled in when MATMUL_TILE_IRQ_EN is defined.
module matmul_tile_ctrl #(
  parameter int REG_ADDRWIDTH = 4,
  parameter int REG_DATAWIDTH = 16,
  parameter int AWIDTH        = 10,
  parameter int MAT_MUL_SIZE  = 4,
  parameter int FLAG_W        = 5
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [REG_ADDRWIDTH-1:0] PADDR,
  input  logic                     PWRITE,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic [REG_DATAWIDTH-1:0] PWDATA,
  output logic [REG_DATAWIDTH-1:0] PRDATA,
  output logic                     PREADY,
  output logic                     core_start,
  input  logic                     core_done,
  input  logic [FLAG_W-1:0]        core_flags,
  output logic [AWIDTH-1:0]        addr_a,
  output logic [AWIDTH-1:0]        addr_b,
  output logic [AWIDTH-1:0]        addr_c,
  output logic [REG_DATAWIDTH-1:0] stride_a,
  output logic [REG_DATAWIDTH-1:0] stride_b,
  output logic [REG_DATAWIDTH-1:0] stride_c,
  output logic                     pe_resetn,
  output logic                     irq
);

  localparam int SHIFT = $clog2(MAT_MUL_SIZE);

  localparam logic [REG_ADDRWIDTH-1:0] R_CTRL     = REG_ADDRWIDTH'(0);
  localparam logic [REG_ADDRWIDTH-1:0] R_BASE_A   = REG_ADDRWIDTH'(1);
  localparam logic [REG_ADDRWIDTH-1:0] R_BASE_B   = REG_ADDRWIDTH'(2);
  localparam logic [REG_ADDRWIDTH-1:0] R_BASE_C   = REG_ADDRWIDTH'(3);
  localparam logic [REG_ADDRWIDTH-1:0] R_STRIDE_A = REG_ADDRWIDTH'(4);
  localparam logic [REG_ADDRWIDTH-1:0] R_STRIDE_B = REG_ADDRWIDTH'(5);
  localparam logic [REG_ADDRWIDTH-1:0] R_STRIDE_C = REG_ADDRWIDTH'(6);
  localparam logic [REG_ADDRWIDTH-1:0] R_STATUS   = REG_ADDRWIDTH'(7);
  localparam logic [REG_ADDRWIDTH-1:0] R_NUM      = REG_ADDRWIDTH'(8);
  localparam logic [REG_ADDRWIDTH-1:0] R_TILE_CNT = REG_ADDRWIDTH'(9);
`ifdef MATMUL_TILE_IRQ_EN
  localparam logic [REG_ADDRWIDTH-1:0] R_IRQ_EN   = REG_ADDRWIDTH'(10);
  localparam logic [REG_ADDRWIDTH-1:0] R_IRQ_STAT = REG_ADDRWIDTH'(11);
`endif

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, ADVANCE, DONE} state_t;

  state_t                   state;
  logic [1:0]               ctrl;
  logic                     ctrl0_q;
  logic [REG_DATAWIDTH-1:0] base_a, base_b, base_c, num_tiles, tile_cnt;
  logic                     done;
  logic [FLAG_W-1:0]        flags;

  logic                     wr_en, rd_en, busy, start_go, run_done, last_tile, enter_done;
  logic [REG_DATAWIDTH-1:0] last_idx, status, rd_mux;
  logic [AWIDTH-1:0]        step_a, step_b, step_c;

  assign PREADY     = 1'b1;
  assign wr_en      = PSEL & PENABLE & PWRITE;
  assign rd_en      = PSEL & ~PENABLE & ~PWRITE;
  assign busy       = (state == LAUNCH) || (state == RUN) || (state == ADVANCE);
  assign start_go   = (state == IDLE) & ctrl[0] & ~ctrl0_q;
  assign run_done   = (state == RUN) & ctrl[0] & core_done;
  assign last_idx   = (num_tiles == '0) ? '0 : num_tiles - REG_DATAWIDTH'(1);
  assign last_tile  = (tile_cnt == last_idx);
  assign enter_done = (state == ADVANCE) & ctrl[0] & last_tile;
  // Per-tile step is stride*MAT_MUL_SIZE, wrapping in the BRAM address space.
  assign step_a     = AWIDTH'(stride_a << SHIFT);
  assign step_b     = AWIDTH'(stride_b << SHIFT);
  assign step_c     = AWIDTH'(stride_c << SHIFT);
  assign status     = REG_DATAWIDTH'({busy, flags, done});

  // Configuration writes; tile geometry is frozen while a run is in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl      <= 2'b00;
      base_a    <= '0;
      base_b    <= '0;
      base_c    <= '0;
      stride_a  <= '0;
      stride_b  <= '0;
      stride_c  <= '0;
      num_tiles <= '0;
    end else if (wr_en) begin
      case (PADDR)
        R_CTRL:     ctrl <= PWDATA[1:0];
        R_BASE_A:   if (!busy) base_a <= PWDATA;
        R_BASE_B:   if (!busy) base_b <= PWDATA;
        R_BASE_C:   if (!busy) base_c <= PWDATA;
        R_STRIDE_A: if (!busy) stride_a <= PWDATA;
        R_STRIDE_B: if (!busy) stride_b <= PWDATA;
        R_STRIDE_C: if (!busy) stride_c <= PWDATA;
        R_NUM:      if (!busy) num_tiles <= PWDATA;
        default: begin end
      endcase
    end
  end

  // Tile sequencer; clearing CTRL[0] aborts from any busy state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      ctrl0_q    <= 1'b0;
      core_start <= 1'b0;
      pe_resetn  <= 1'b0;
      tile_cnt   <= '0;
      done       <= 1'b0;
      flags      <= '0;
      addr_a     <= '0;
      addr_b     <= '0;
      addr_c     <= '0;
    end else begin
      ctrl0_q    <= ctrl[0];
      core_start <= 1'b0;
      pe_resetn  <= ~(ctrl[1] | start_go);
      case (state)
        IDLE: begin
          if (start_go) begin
            state    <= LAUNCH;
            done     <= 1'b0;
            flags    <= '0;
            tile_cnt <= '0;
            addr_a   <= base_a[AWIDTH-1:0];
            addr_b   <= base_b[AWIDTH-1:0];
            addr_c   <= base_c[AWIDTH-1:0];
          end
        end
        LAUNCH: begin
          if (!ctrl[0]) begin
            state <= IDLE;
          end else begin
            core_start <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (!ctrl[0]) begin
            state <= IDLE;
          end else if (run_done) begin
            flags <= flags | core_flags;
            state <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (!ctrl[0]) begin
            state <= IDLE;
          end else if (enter_done) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            tile_cnt <= tile_cnt + REG_DATAWIDTH'(1);
            addr_a   <= addr_a + step_a;
            addr_b   <= addr_b + step_b;
            addr_c   <= addr_c + step_c;
            state    <= LAUNCH;
          end
        end
        DONE: begin
          if (!ctrl[0]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MATMUL_TILE_IRQ_EN
  logic [1:0] irq_en, irq_stat, irq_set, irq_clr;
  logic       flag_new;

  assign flag_new = run_done & (|(core_flags & ~flags));
  assign irq_set  = {flag_new, enter_done};
  assign irq_clr  = (wr_en && (PADDR == R_IRQ_STAT)) ? PWDATA[1:0] : 2'b00;

  // Interrupt status: W1C, with a same-cycle set taking priority over the clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_en   <= 2'b00;
      irq_stat <= 2'b00;
      irq      <= 1'b0;
    end else begin
      if (wr_en && (PADDR == R_IRQ_EN)) irq_en <= PWDATA[1:0];
      irq_stat <= (irq_stat & ~irq_clr) | irq_set;
      irq      <= |(irq_stat & irq_en);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Register read mux.
  always_comb begin
    rd_mux = '0;
    case (PADDR)
      R_CTRL:     rd_mux = REG_DATAWIDTH'(ctrl);
      R_BASE_A:   rd_mux = base_a;
      R_BASE_B:   rd_mux = base_b;
      R_BASE_C:   rd_mux = base_c;
      R_STRIDE_A: rd_mux = stride_a;
      R_STRIDE_B: rd_mux = stride_b;
      R_STRIDE_C: rd_mux = stride_c;
      R_STATUS:   rd_mux = status;
      R_NUM:      rd_mux = num_tiles;
      R_TILE_CNT: rd_mux = tile_cnt;
`ifdef MATMUL_TILE_IRQ_EN
      R_IRQ_EN:   rd_mux = REG_DATAWIDTH'(irq_en);
      R_IRQ_STAT: rd_mux = REG_DATAWIDTH'(irq_stat);
`endif
      default:    rd_mux = '0;
    endcase
  end

  // Read data is captured in the setup phase and held until the next read.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      PRDATA <= '0;
    end else if (rd_en) begin
      PRDATA <= rd_mux;
    end
  end

endmodule

// File: tb/tb_matmul_tile_ctrl.sv
// Directed bench for matmul_tile_ctrl: a transaction-level model predicts pulse timing,
// tile addresses and register contents; the bench also acts as the matmul core.
module tb_matmul_tile_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  PADDR;
  logic        PWRITE, PSEL, PENABLE;
  logic [15:0] PWDATA, PRDATA;
  logic        PREADY, core_start, core_done, pe_resetn, irq;
  logic [4:0]  core_flags;
  logic [9:0]  addr_a, addr_b, addr_c;
  logic [15:0] stride_a, stride_b, stride_c;

  matmul_tile_ctrl dut (
    .clk(clk), .resetn(resetn), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .core_start(core_start), .core_done(core_done), .core_flags(core_flags),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
    .stride_a(stride_a), .stride_b(stride_b), .stride_c(stride_c),
    .pe_resetn(pe_resetn), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int NEVER = 1 << 30;

  // Model state: phase 0 idle, 1 running, 2 done.
  logic [15:0] mreg [16];
  int          m_phase, m_k, m_next, m_go_low, m_sr_from, m_sr_to, m_irq_set, m_irq_clr;
  logic [4:0]  m_flags;
  logic        m_done;
  logic [1:0]  m_istat;
  bit          cmp_on, irq_track, exp_cs, exp_pe;
  int          pulses;
  logic [9:0]  obs_a [$];
  int          resp_delay;
  logic [4:0]  resp_flags;
  int          nvec, nerr;
  logic [15:0] rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int eff_tiles();
    return (mreg[8] == 16'd0) ? 1 : int'(mreg[8]);
  endfunction

  function automatic logic [9:0] exp_addr(input int x);
    logic [31:0] v;
    v = 32'(mreg[1+x]) + 32'(m_k) * 32'(mreg[4+x]) * 32'd4;
    return v[9:0];
  endfunction

  function automatic logic [15:0] model_read(input int a);
    case (a)
      0, 1, 2, 3, 4, 5, 6, 8: return mreg[a];
      7: return {9'd0, (m_phase == 1), m_flags, m_done};
      9: return 16'(m_k);
`ifdef MATMUL_TILE_IRQ_EN
      10: return mreg[10];
      11: return {14'd0, m_istat};
`endif
      default: return 16'd0;
    endcase
  endfunction

  task automatic model_write(input int a, input logic [15:0] d, input int c);
    logic [15:0] old;
    case (a)
      0: begin
        old = mreg[0];
        mreg[0] = {14'd0, d[1:0]};
        if (d[1] && !old[1]) begin m_sr_from = c + 1; m_sr_to = NEVER; end
        if (!d[1] && old[1]) m_sr_to = c + 1;
        if (d[0] && !old[0] && m_phase == 0) begin
          m_phase = 1; m_k = 0; m_flags = 5'd0; m_done = 1'b0;
          m_next = c + 2; m_go_low = c + 1;
        end else if (!d[0] && m_phase == 1) begin
          m_phase = 0; m_next = -1;
        end else if (!d[0] && m_phase == 2) begin
          m_phase = 0;
        end
      end
      1, 2, 3, 4, 5, 6, 8: if (m_phase != 1) mreg[a] = d;
      10: mreg[10] = {14'd0, d[1:0]};
      11: begin m_istat = m_istat & ~d[1:0]; m_irq_clr = c + 1; end
      default: begin end
    endcase
  endtask

  task automatic apb_write(input int a, input logic [15:0] d);
    @(posedge clk); #1 PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a[3:0]; PWDATA = d;
    @(posedge clk); #1 PENABLE = 1'b1;
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    model_write(a, d, cyc);
  endtask

  task automatic apb_read(input int a, output logic [15:0] d);
    @(posedge clk); #1 PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a[3:0];
    @(posedge clk); #1 PENABLE = 1'b1;
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0;
    d = PRDATA;
  endtask

  task automatic read_chk(input int a, input string nm);
    logic [15:0] d;
    apb_read(a, d);
    chk(nm, d, model_read(a));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && m_phase != 2; i++) @(posedge clk);
    chk("run_completion", m_phase == 2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Core stand-in: answer each core_start with core_done after resp_delay cycles.
  // A done raised after edge P yields the next core_start after edge P+3.
  initial begin
    core_done = 1'b0; core_flags = 5'd0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        repeat (resp_delay) @(posedge clk);
        #1;
        if (m_phase == 1) begin
          if ((resp_flags & ~m_flags) != 5'd0) m_istat[1] = 1'b1;
          m_flags = m_flags | resp_flags;
          if (m_k == eff_tiles() - 1) begin
            m_phase = 2; m_done = 1'b1; m_istat[0] = 1'b1; m_irq_set = cyc + 3; m_next = -1;
          end else begin
            m_k++; m_next = cyc + 3;
          end
        end
        core_done = 1'b1; core_flags = resp_flags;
        @(posedge clk); #1 core_done = 1'b0; core_flags = 5'd0;
      end
    end
  end

  // Per-cycle compare of the free-running outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        exp_cs = (cyc == m_next);
        exp_pe = (cyc != m_go_low) && !(cyc >= m_sr_from && cyc < m_sr_to);
        chk("core_start", core_start, exp_cs);
        chk("pready", PREADY, 1'b1);
        chk("pe_resetn", pe_resetn, exp_pe);
        if (core_start === 1'b1) begin pulses++; obs_a.push_back(addr_a); end
        if (exp_cs) begin
          chk("addr_a", addr_a, exp_addr(0));
          chk("addr_b", addr_b, exp_addr(1));
          chk("addr_c", addr_c, exp_addr(2));
        end
`ifdef MATMUL_TILE_IRQ_EN
        if (irq_track) chk("irq", irq, (cyc >= m_irq_set && cyc < m_irq_clr));
`else
        chk("irq_tied", irq, 1'b0);
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mreg[i] = 16'd0;
    m_phase = 0; m_k = 0; m_next = -1; m_go_low = -1; m_sr_from = NEVER; m_sr_to = NEVER;
    m_irq_set = NEVER; m_irq_clr = NEVER; m_flags = 5'd0; m_done = 1'b0; m_istat = 2'b00;
    cmp_on = 1'b0; irq_track = 1'b0; pulses = 0; nvec = 0; nerr = 0;
    resp_delay = 10; resp_flags = 5'd0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'd0; PWDATA = 16'd0;

    // Reset held for 3 cycles.
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pe_resetn", pe_resetn, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_prdata", PRDATA, 16'h0000);
    chk("rst_irq", irq, 1'b0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1 cmp_on = 1'b1;
    for (int a = 0; a < 16; a++) read_chk(a, "rst_read");

    // PE soft reset through CTRL[1].
    apb_write(0, 16'h0002);
    repeat (3) @(posedge clk);
    #1 chk("soft_rst_low", pe_resetn, 1'b0);
    apb_write(0, 16'h0000);
    repeat (2) @(posedge clk);
    #1 chk("soft_rst_release", pe_resetn, 1'b1);

    // Single tile with one flag bit.
    apb_write(4, 16'd1); apb_write(5, 16'd1); apb_write(6, 16'd1); apb_write(8, 16'd0);
    resp_delay = 10; resp_flags = 5'b00100; pulses = 0;
    apb_write(0, 16'h0001);
    wait_done();
    apb_read(7, rd);
    chk("single_status", rd, 16'h0009);
    chk("single_status_model", rd, model_read(7));
    read_chk(9, "single_tile_cnt");
    read_chk(0, "single_ctrl");
    chk("single_pulses", pulses, 1);
    apb_write(0, 16'h0000);
    repeat (2) @(posedge clk);
    apb_read(7, rd);
    chk("single_status_after_stop", rd, 16'h0009);

    // Three tiles with distinct bases and strides.
    apb_write(1, 16'd8);   apb_write(4, 16'd2);
    apb_write(2, 16'd100); apb_write(5, 16'd3);
    apb_write(3, 16'd1008); apb_write(6, 16'd5);
    apb_write(8, 16'd3);
    resp_delay = 4; resp_flags = 5'd0; pulses = 0; obs_a.delete();
    apb_write(0, 16'h0001);
    wait_done();
    chk("multi_pulses", pulses, 3);
    chk("multi_addr0", obs_a[0], 10'd8);
    chk("multi_addr1", obs_a[1], 10'd16);
    chk("multi_addr2", obs_a[2], 10'd24);
    apb_read(9, rd);
    chk("multi_tile_cnt", rd, 16'd2);
    read_chk(7, "multi_status");
    apb_write(0, 16'h0000);

    // Address wrap across the 10-bit BRAM space.
    apb_write(1, 16'd1020); apb_write(4, 16'd1); apb_write(8, 16'd2);
    pulses = 0; obs_a.delete();
    apb_write(0, 16'h0001);
    wait_done();
    chk("wrap_pulses", pulses, 2);
    chk("wrap_addr0", obs_a[0], 10'd1020);
    chk("wrap_addr1", obs_a[1], 10'd0);
    apb_write(0, 16'h0000);

    // Busy lock and abort during RUN.
    apb_write(8, 16'd3);
    resp_delay = 20; resp_flags = 5'b00011; pulses = 0;
    apb_write(0, 16'h0001);
    for (int i = 0; i < 50 && pulses == 0; i++) @(posedge clk);
    chk("abort_first_pulse", pulses, 1);
    apb_write(1, 16'd5);
    apb_read(1, rd);
    chk("busy_lock_base_a", rd, 16'd1020);
    chk("busy_lock_model", rd, model_read(1));
    apb_write(0, 16'h0000);
    repeat (40) @(posedge clk);
    chk("abort_pulses", pulses, 1);
    apb_read(7, rd);
    chk("abort_status", rd, 16'h0000);
    chk("abort_status_model", rd, model_read(7));

`ifdef MATMUL_TILE_IRQ_EN
    // Interrupt on completion and W1C clear.
    apb_write(11, 16'h0003);
    apb_write(10, 16'h0001);
    m_irq_set = NEVER; m_irq_clr = NEVER; irq_track = 1'b1;
    apb_write(8, 16'd0);
    resp_delay = 5; resp_flags = 5'd0;
    apb_write(0, 16'h0001);
    wait_done();
    chk("irq_raised", irq, 1'b1);
    apb_read(11, rd);
    chk("irq_stat_done", rd, 16'h0001);
    read_chk(10, "irq_en_read");
    apb_write(11, 16'h0001);
    repeat (2) @(posedge clk);
    #1 chk("irq_cleared", irq, 1'b0);
    read_chk(11, "irq_stat_cleared");
    apb_write(0, 16'h0000);
`else
    // Interrupt registers absent: writes ignored, reads zero.
    apb_write(10, 16'h0001);
    apb_write(11, 16'h0003);
    apb_read(10, rd);
    chk("irq_en_absent", rd, 16'h0000);
    read_chk(11, "irq_stat_absent");
    chk("irq_absent", irq, 1'b0);
`endif

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
